stream_demux_n: RTL and testbench

- Registered 1-to-NUM_CH stream demultiplexer with valid/ready handshakes. It is the parametrised successor of the combinational 1-to-4 demux.
- It routes an input data stream to one of NUM_CH output channels. Routing is either by explicit select or by round-robin in bursts of BURST_LEN beats.
- It sits between the feature-map/weight loader and the PE-row input buffers of the CNN datapath.
- Each channel has a one-entry output register, so a stalled channel does not corrupt the other channels.

---
 rtl/stream_demux_n_pkg.sv | 14 +
 rtl/stream_demux_n_out_reg.sv | 48 ++++
 rtl/stream_demux_n.sv | 115 +++++++++++
 tb/tb_stream_demux_n.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_n_pkg.sv
// Shared definitions for the CNN stream-routing blocks.
//   MODE_EXPLICIT / MODE_RR : encodings of the demux mode_i input.
//   clog2_min1              : ceil(log2(n)), never less than 1, so that a
//                             select or counter field is always at least one bit wide.
package cnn_stream_pkg;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_n_out_reg.sv
// One-entry valid/ready output register for a single demux channel.
//   clk, rst_n : clock and synchronous active-low reset
//   load_i     : a beat is accepted for this channel this cycle
//   data_i     : beat to capture on load
//   ready_i    : downstream ready
//   valid_o    : entry occupied
//   data_o     : held beat (keeps its value after a drain)
module demux_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // A load wins over a drain in the same cycle, giving 1 beat/cycle throughput.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-NUM_CH stream demultiplexer with valid/ready handshakes.
// Routes each beat by explicit select (mode_i=0) or round-robin in bursts of
// BURST_LEN beats (mode_i=1). Every channel has its own one-entry register.
//   clk, rst_n  : clock and synchronous active-low reset
//   clear_i     : clear round-robin pointer and beat counter
//   mode_i      : 0 = explicit select, 1 = round-robin
//   s_valid/s_ready/s_data/s_sel : input stream and explicit target
//   m_valid/m_ready/m_data       : per-channel outputs, channel k at [k*DATA_W +: DATA_W]
//   rr_ch_o     : current round-robin pointer
//   sel_err_o   : one-cycle pulse after an out-of-range select beat was dropped
module stream_demux_n
  import cnn_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SEL_W     = clog2_min1(NUM_CH),
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     mode_i,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [SEL_W-1:0]         s_sel,
  output logic [NUM_CH-1:0]        m_valid,
  input  logic [NUM_CH-1:0]        m_ready,
  output logic [NUM_CH*DATA_W-1:0] m_data,
  output logic [SEL_W-1:0]         rr_ch_o,
  output logic                     sel_err_o
);

  localparam int unsigned       CNT_W     = clog2_min1(BURST_LEN);
  localparam logic [SEL_W:0]    NUM_CH_X  = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0]  LAST_CH   = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [SEL_W-1:0]  rr_q,  rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [SEL_W-1:0]  tgt;
  logic              sel_ok;
  logic              tgt_busy;
  logic              accept;
  logic [NUM_CH-1:0] load;

  always_comb begin
    tgt    = (mode_i == MODE_RR) ? rr_q : s_sel;
    sel_ok = (mode_i == MODE_RR) || ({1'b0, s_sel} < NUM_CH_X);

    // Decode instead of indexing m_valid[tgt] so an out-of-range select never
    // reads past the vector; such a beat sees an idle target and is consumed.
    tgt_busy = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (tgt == SEL_W'(k)) tgt_busy = m_valid[k] & ~m_ready[k];
    end

    s_ready = rst_n & ~tgt_busy;
    accept  = s_valid & s_ready;

    load = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      load[k] = accept & sel_ok & (tgt == SEL_W'(k));
    end
  end

  always_comb begin
    rr_d  = rr_q;
    cnt_d = cnt_q;
    err_d = accept & ~sel_ok;
    if (clear_i) begin
      rr_d  = '0;
      cnt_d = '0;
    end else if (accept && (mode_i == MODE_RR)) begin
      if (cnt_q == LAST_BEAT) begin
        cnt_d = '0;
        rr_d  = (rr_q == LAST_CH) ? '0 : rr_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rr_ch_o   = rr_q;
  assign sel_err_o = err_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_out_reg #(
      .DATA_W(DATA_W)
    ) u_out_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load[k]),
      .data_i (s_data),
      .ready_i(m_ready[k]),
      .valid_o(m_valid[k]),
      .data_o (m_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_stream_demux_n.sv
module tb_stream_demux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear_i, mode_i, s_valid;
  logic [7:0] s_data;
  logic [1:0] s_sel;
  logic [3:0] m_ready;

  logic        s_ready4, err4;
  logic [3:0]  m_valid4;
  logic [31:0] m_data4;
  logic [1:0]  rr4;

  logic        s_ready3, err3;
  logic [2:0]  m_valid3;
  logic [23:0] m_data3;
  logic [1:0]  rr3;

  stream_demux_n #(.DATA_W(8), .NUM_CH(4), .BURST_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .mode_i(mode_i),
    .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data), .s_sel(s_sel),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .rr_ch_o(rr4), .sel_err_o(err4));

  stream_demux_n #(.DATA_W(8), .NUM_CH(3), .BURST_LEN(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .mode_i(mode_i),
    .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data), .s_sel(s_sel),
    .m_valid(m_valid3), .m_ready(m_ready[2:0]), .m_data(m_data3),
    .rr_ch_o(rr3), .sel_err_o(err3));

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // Behavioural model: index 0 models the 4-channel DUT, index 1 the 3-channel one.
  localparam int BL = 4;
  int mv [2][4];
  int md [2][4];
  int rr [2];
  int cnt[2];
  int err[2];

  function automatic int nch(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int exp_ready(input int i);
    int t;
    if (!rst_n) return 0;
    if (!mode_i && (int'(s_sel) >= nch(i))) return 1;
    t = mode_i ? rr[i] : int'(s_sel);
    return (mv[i][t] == 0 || m_ready[t]) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin mv[i][k] = 0; md[i][k] = 0; end
        rr[i] = 0; cnt[i] = 0; err[i] = 0;
      end else begin
        int  t;
        bit  oor, acc;
        oor = !mode_i && (int'(s_sel) >= nch(i));
        t   = mode_i ? rr[i] : int'(s_sel);
        acc = s_valid && (exp_ready(i) != 0);
        for (int k = 0; k < nch(i); k++)
          if (mv[i][k] != 0 && m_ready[k]) mv[i][k] = 0;
        if (acc && !oor) begin mv[i][t] = 1; md[i][t] = int'(s_data); end
        err[i] = (acc && oor) ? 1 : 0;
        if (clear_i) begin
          rr[i] = 0; cnt[i] = 0;
        end else if (acc && mode_i) begin
          if (cnt[i] == BL - 1) begin cnt[i] = 0; rr[i] = (rr[i] + 1) % nch(i); end
          else cnt[i] = cnt[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [3:0]  ev4; logic [31:0] ed4;
      logic [2:0]  ev3; logic [23:0] ed3;
      ev4 = '0; ed4 = '0; ev3 = '0; ed3 = '0;
      for (int k = 0; k < 4; k++) begin ev4[k] = (mv[0][k] != 0); ed4[k*8 +: 8] = 8'(md[0][k]); end
      for (int k = 0; k < 3; k++) begin ev3[k] = (mv[1][k] != 0); ed3[k*8 +: 8] = 8'(md[1][k]); end
      chk("m4_valid", 32'(m_valid4), 32'(ev4));
      chk("m4_data",  m_data4, ed4);
      chk("m4_rr",    32'(rr4), 32'(rr[0]));
      chk("m4_err",   32'(err4), 32'(err[0]));
      chk("m4_ready", 32'(s_ready4), 32'(exp_ready(0)));
      chk("m3_valid", 32'(m_valid3), 32'(ev3));
      chk("m3_data",  32'(m_data3), 32'(ed3));
      chk("m3_rr",    32'(rr3), 32'(rr[1]));
      chk("m3_err",   32'(err3), 32'(err[1]));
      chk("m3_ready", 32'(s_ready3), 32'(exp_ready(1)));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear_i = 1'b0; mode_i = 1'b0; s_valid = 1'b0;
    s_data = '0; s_sel = '0; m_ready = 4'hF;
    tick; tick;
    started = 1'b1;
    chk("rst_sready", 32'(s_ready4), 0);
    chk("rst_valid",  32'(m_valid4), 0);
    chk("rst_data",   m_data4, 0);
    chk("rst_rr",     32'(rr4), 0);
    chk("rst_err",    32'(err4), 0);
    rst_n = 1'b1;

    // Explicit routing to each channel.
    for (int k = 0; k < 4; k++) begin
      s_sel = 2'(k); s_data = 8'(8'hA0 + k); s_valid = 1'b1;
      #1 chk("exp_sready", 32'(s_ready4), 1);
      tick;
      chk("exp_valid", 32'(m_valid4), 32'(1 << k));
      chk("exp_data",  32'(m_data4[k*8 +: 8]), 32'(8'hA0 + k));
    end
    s_valid = 1'b0; tick;

    // Backpressure on channel 2.
    m_ready = 4'b1011;
    s_sel = 2'd2; s_data = 8'h11; s_valid = 1'b1; tick;
    chk("bp_first", 32'(m_data4[23:16]), 32'h11);
    s_data = 8'h22;
    #1 chk("bp_stall_ready", 32'(s_ready4), 0);
    tick;
    chk("bp_hold", 32'(m_data4[23:16]), 32'h11);
    s_sel = 2'd1; s_data = 8'h33;
    #1 chk("bp_other_ready", 32'(s_ready4), 1);
    tick;
    chk("bp_other_valid", 32'(m_valid4), 32'b0110);
    chk("bp_other_data",  32'(m_data4[15:8]), 32'h33);
    s_sel = 2'd2; s_data = 8'h22; m_ready = 4'hF;
    #1 chk("bp_release_ready", 32'(s_ready4), 1);
    tick;
    chk("bp_release_valid", 32'(m_valid4), 32'b0100);
    chk("bp_release_data",  32'(m_data4[23:16]), 32'h22);
    s_valid = 1'b0; tick;

    // Round-robin, 16 beats.
    mode_i = 1'b1; clear_i = 1'b1; tick; clear_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_data = 8'(i); s_valid = 1'b1; tick;
      chk("rr_valid", 32'(m_valid4), 32'(1 << (i / 4)));
      chk("rr_data",  32'(m_data4[(i / 4) * 8 +: 8]), 32'(i));
      chk("rr_ptr",   32'(rr4), 32'(((i + 1) / 4) % 4));
    end
    chk("rr_model_ptr", 32'(rr[0]), 0);

    // clear_i on the last beat of a burst.
    for (int i = 0; i < 4; i++) begin
      s_data = 8'(i); clear_i = (i == 3); tick;
    end
    clear_i = 1'b0;
    chk("clr_data3", 32'(m_data4[7:0]), 3);
    chk("clr_ptr",   32'(rr4), 0);
    s_data = 8'd4; tick;
    chk("clr_valid4", 32'(m_valid4), 32'b0001);
    chk("clr_data4",  32'(m_data4[7:0]), 4);
    s_valid = 1'b0; tick;

    // Out-of-range select on the 3-channel instance.
    mode_i = 1'b0; s_sel = 2'd3; s_data = 8'h55; s_valid = 1'b1;
    #1 chk("oor_ready", 32'(s_ready3), 1);
    tick;
    chk("oor_err",   32'(err3), 1);
    chk("oor_valid", 32'(m_valid3), 0);
    s_valid = 1'b0; tick;
    chk("oor_err_clr", 32'(err3), 0);

    // Reset while channels 1 and 3 are stalled.
    m_ready = 4'h0;
    s_sel = 2'd1; s_data = 8'hC1; s_valid = 1'b1; tick;
    s_sel = 2'd3; s_data = 8'hC3; tick;
    s_valid = 1'b0;
    chk("mid_valid", 32'(m_valid4), 32'b1010);
    rst_n = 1'b0;
    #1 chk("mid_rst_ready", 32'(s_ready4), 0);
    tick;
    chk("mid_rst_valid", 32'(m_valid4), 0);
    chk("mid_rst_data",  m_data4, 0);
    chk("mid_rst_rr",    32'(rr4), 0);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      if ($urandom_range(0, 15) == 0) mode_i = ~mode_i;
      s_sel   = 2'($urandom);
      m_ready = 4'($urandom | $urandom);
      clear_i = ($urandom_range(0, 31) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      tick;
    end
    rst_n = 1'b1; s_valid = 1'b0; clear_i = 1'b0;
    tick; tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
